// File: rtl/ram_dp_16x32_pkg.sv
// Shared constants, types and helpers for the 16x32 dual-port RAM.
// Combinational only; no storage.
// No flow control.
package ram_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 4;
    localparam int DEPTH      = 2 ** ADDR_WIDTH;
    localparam int CNT_WIDTH  = 16;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [CNT_WIDTH-1:0]  cnt_t;

    // Counters stick at all-ones instead of wrapping.
    function automatic cnt_t sat_inc(input cnt_t c);
        return (&c) ? c : c + cnt_t'(1);
    endfunction

endpackage

// File: rtl/ram_dp_16x32_if.sv
// Bundles the request and result signals between the RAM drivers and the RAM.
// Wires only; no storage or latency.
// No flow control: requests are sampled every clock.
interface ram_dp_16x32_if;
    import ram_pkg::*;

    logic  wr_enable;
    addr_t wr_addr;
    data_t data_in;
    logic  rd_enable;
    addr_t rd_addr;
    data_t data_out;
    logic  rd_valid;
    logic  rd_uninit;
    cnt_t  wr_count;
    cnt_t  rd_count;

    modport master (
        output wr_enable, wr_addr, data_in, rd_enable, rd_addr,
        input  data_out, rd_valid, rd_uninit, wr_count, rd_count
    );

    modport slave (
        input  wr_enable, wr_addr, data_in, rd_enable, rd_addr,
        output data_out, rd_valid, rd_uninit, wr_count, rd_count
    );

endinterface

// File: rtl/ram_dp_16x32_storage_array.sv
// Plain DEPTH x DATA_WIDTH storage, one synchronous write port, one async read port.
// Write lands at posedge; read is combinational.
// No flow control; contents are never reset.
module ram_storage_array
    import ram_pkg::*;
(
    input  logic  clk,
    input  logic  we,
    input  addr_t waddr,
    input  data_t wdata,
    input  addr_t raddr,
    output data_t rdata
);

    data_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ram_dp_16x32.sv
// Dual-port 16x32 RAM with registered read, write-first bypass, init tracking and access counters.
// Read data and rd_valid appear one cycle after rd_enable.
// No backpressure: every request is accepted in the cycle it is presented.
module ram_dp_16x32
    import ram_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    ram_dp_16x32_if.slave bus
);

    logic [DEPTH-1:0] written_map;
    data_t            arr_rdata;
    data_t            data_out_q;
    logic             rd_valid_q;
    logic             rd_uninit_q;
    cnt_t             wr_count_q;
    cnt_t             rd_count_q;
    logic             wr_same_addr;

    // Reset has priority, so a write in the reset cycle must not reach the array.
    ram_storage_array u_array (
        .clk   (clk),
        .we    (bus.wr_enable & ~rst),
        .waddr (bus.wr_addr),
        .wdata (bus.data_in),
        .raddr (bus.rd_addr),
        .rdata (arr_rdata)
    );

    assign wr_same_addr = bus.wr_enable && (bus.wr_addr == bus.rd_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            written_map <= '0;
            data_out_q  <= '0;
            rd_valid_q  <= 1'b0;
            rd_uninit_q <= 1'b0;
            wr_count_q  <= '0;
            rd_count_q  <= '0;
        end else begin
            rd_valid_q <= bus.rd_enable;
            if (bus.wr_enable) begin
                written_map[bus.wr_addr] <= 1'b1;
                wr_count_q               <= sat_inc(wr_count_q);
            end
            if (bus.rd_enable) begin
                rd_count_q <= sat_inc(rd_count_q);
                // Never-written entries return zero so stale array words stay hidden.
                if (wr_same_addr) begin
                    data_out_q  <= bus.data_in;
                    rd_uninit_q <= 1'b0;
                end else if (!written_map[bus.rd_addr]) begin
                    data_out_q  <= '0;
                    rd_uninit_q <= 1'b1;
                end else begin
                    data_out_q  <= arr_rdata;
                    rd_uninit_q <= 1'b0;
                end
            end
        end
    end

    assign bus.data_out  = data_out_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_uninit = rd_uninit_q;
    assign bus.wr_count  = wr_count_q;
    assign bus.rd_count  = rd_count_q;

endmodule
